i2s_slave_port: RTL and testbench
=================================

I2S_SLAVE_PORT -- requirements
Module: i2s_slave_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the audio word width in bits, legal range 16..32.
REQ-002 The block SHALL have parameter SLOT, default 32, giving BCLK cycles per channel slot, legal range WIDTH..32.
REQ-003 Port clk SHALL be an input, 1 bit: the single system clock, at least 8x the BCLK frequency.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port BCLK SHALL be an input, 1 bit: asynchronous bit clock from the link master.
REQ-006 Port LRCLK SHALL be an input, 1 bit: asynchronous word select, 0 = left, 1 = right.
REQ-007 Port SDATA_IN SHALL be an input, 1 bit: serial data received from the master.
REQ-008 Port SDATA_OUT SHALL be an output, 1 bit: serial data driven to the master.
REQ-009 Ports TxLeft and TxRight SHALL be inputs, WIDTH bits each: words to transmit.
REQ-010 Ports RxLeft and RxRight SHALL be outputs, WIDTH bits each: received words.
REQ-011 Port RxValid SHALL be an output, 1 bit: one-clk pulse when RxLeft/RxRight update.
REQ-012 Port TxLatch SHALL be an output, 1 bit: one-clk pulse when TxLeft/TxRight are captured.
REQ-013 Port Locked SHALL be an output, 1 bit: framing acquired.
REQ-014 Port SyncErr SHALL be an output, 1 bit: sticky short- or long-slot error flag.

Function
REQ-015 The block SHALL pass BCLK, LRCLK and SDATA_IN through two-flop synchronizers and then detect BCLK rising and falling edges in clk.
REQ-016 The block SHALL sample SDATA_IN only on a detected BCLK rise and SHALL change SDATA_OUT only on a detected BCLK fall.
REQ-017 The block SHALL have state machine states UNLOCKED, LEFT and RIGHT.
REQ-018 In UNLOCKED, the block SHALL drive SDATA_OUT to 0 and SHALL move to LEFT on the first LRCLK 1->0 change seen at a BCLK fall.
REQ-019 The block SHALL move LEFT->RIGHT on an LRCLK 0->1 change and RIGHT->LEFT on an LRCLK 1->0 change, both evaluated at a BCLK fall.
REQ-020 Each LRCLK change SHALL restart the slot bit counter at 0.
REQ-021 Entry to LEFT SHALL capture TxLeft and TxRight into shadow registers and SHALL pulse TxLatch in the same clk cycle.
REQ-022 In default (I2S) mode, the MSB SHALL appear on SDATA_OUT at the BCLK fall one BCLK after the LRCLK change, with MSB-first order.
REQ-023 Slot bits beyond WIDTH SHALL be driven as 0.
REQ-024 The block SHALL shift received bits MSB-first, with the same one-BCLK offset, into a WIDTH-bit shift register per channel, and SHALL ignore bits beyond WIDTH.
REQ-025 When the right-channel LSB is sampled, RxLeft and RxRight SHALL both update on the next clk and RxValid SHALL pulse for exactly 1 clk.
REQ-026 An LRCLK change after fewer than WIDTH+1 BCLKs in the slot (short slot) SHALL set SyncErr.
REQ-027 On a short slot, the partial receive word SHALL be discarded with no RxValid pulse, and framing SHALL continue with the new slot.
REQ-028 A slot counter exceeding 2*SLOT BCLKs without an LRCLK change SHALL set SyncErr, clear Locked and return the block to UNLOCKED.
REQ-029 Locked SHALL be 1 in LEFT and RIGHT and 0 in UNLOCKED.
REQ-030 SyncErr SHALL clear only on reset.

Reset
REQ-031 While reset is 1 at a clk edge, the state SHALL go to UNLOCKED.
REQ-032 While reset is 1 at a clk edge, SDATA_OUT, RxLeft, RxRight, RxValid, TxLatch, Locked, SyncErr, the shift registers, the counters and the synchronizers SHALL all go to 0.
REQ-033 A reset asserted mid-frame SHALL abort the current words.
REQ-034 After reset, the block SHALL transmit nothing until a fresh LRCLK 1->0 change is seen.

Configuration
REQ-035 With macro I2S_LEFT_JUSTIFIED_EN defined, the MSB SHALL align to the BCLK fall coincident with the LRCLK change (zero-BCLK offset) for both TX and RX.
REQ-036 With I2S_LEFT_JUSTIFIED_EN undefined, the block SHALL use standard I2S framing with a one-BCLK offset.
REQ-037 All other behaviour SHALL be identical in both modes.

Structure
REQ-038 Shared package i2s_pkg SHALL hold the state enumeration (UNLOCKED/LEFT/RIGHT), the default WIDTH and SLOT constants and the synchronizer depth constant.
REQ-039 Sub-module sync_edge SHALL provide the two-flop synchronizer plus rise/fall pulse outputs, instantiated for BCLK and LRCLK; SDATA_IN SHALL use a plain synchronizer.

Verification
REQ-040 Scenario 1: reset, then 3 standard I2S frames with BCLK = clk/16, TxLeft=24'hA5A5A5, TxRight=24'h123456 -> SDATA_OUT bitstreams match MSB-first with a one-BCLK offset, and TxLatch pulses once per frame.
REQ-041 Scenario 2: master sends left 24'h800001 and right 24'h7FFFFF -> RxLeft=24'h800001 and RxRight=24'h7FFFFF, with RxValid high for 1 clk per frame.
REQ-042 Scenario 3: a left slot cut to 10 BCLKs -> SyncErr=1, no RxValid for that frame, Locked stays 1, and the next full frame is received correctly.
REQ-043 Scenario 4: LRCLK held at 0 for 70 BCLKs -> Locked=0, SDATA_OUT=0, and re-lock occurs on the next LRCLK 1->0 change.
REQ-044 Scenario 5: reset pulsed at BCLK 5 of the right slot -> all outputs 0, and the first RxValid after release comes only after a complete new frame.
REQ-045 Scenario 6: I2S_LEFT_JUSTIFIED_EN defined, same data as Scenario 1 -> MSB appears with zero offset and received words match.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S slave port.
// Holds the framing state encoding and default geometry.
package i2s_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LEFT     = 2'd1,
    RIGHT    = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 24;
  localparam int DEF_SLOT   = 32;
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/i2s_slave_port_sync_edge.sv
// Two-flop synchronizer for an asynchronous input,
// with one-clk rise and fall pulses on the synced level.
module sync_edge
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign rise_o = sync_q[SYNC_DEPTH-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_DEPTH-1] & prev_q;

endmodule

// File: rtl/i2s_slave_port.sv
// I2S slave: framing FSM, TX serializer and RX deserializer.
// Define I2S_LEFT_JUSTIFIED_EN for zero-BCLK data offset.
module i2s_slave_port
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLOT  = DEF_SLOT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BCLK,
  input  logic             LRCLK,
  input  logic             SDATA_IN,
  output logic             SDATA_OUT,
  input  logic [WIDTH-1:0] TxLeft,
  input  logic [WIDTH-1:0] TxRight,
  output logic [WIDTH-1:0] RxLeft,
  output logic [WIDTH-1:0] RxRight,
  output logic             RxValid,
  output logic             TxLatch,
  output logic             Locked,
  output logic             SyncErr
);

  localparam int CW = $clog2(2*SLOT+2);
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int OFF = 0;
`else
  localparam int OFF = 1;
`endif

  logic bclk_r, bclk_f, lr_r, lr_f;
  logic [SYNC_DEPTH-1:0] sd_q;
  logic sd;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rpend_q, fpend_q;
  logic [WIDTH-1:0] shl_q, shl_d, shr_q, shr_d;
  logic [WIDTH-1:0] rxl_q, rxr_q, rx_left_q, rx_right_q;
  logic sdo_q, sdo_d, rxv_q, txl_q, err_q, lok_q;
  logic lr_rise, lr_fall, enter_left;
  logic short_slot, long_slot;
  logic [WIDTH-1:0] tx_word, tx_sh;
  logic [CW-1:0] tx_pos, rx_pos;

  sync_edge u_bclk (
    .clk    (clk),
    .reset  (reset),
    .d_i    (BCLK),
    .rise_o (bclk_r),
    .fall_o (bclk_f)
  );

  sync_edge u_lrclk (
    .clk    (clk),
    .reset  (reset),
    .d_i    (LRCLK),
    .rise_o (lr_r),
    .fall_o (lr_f)
  );

  assign sd = sd_q[SYNC_DEPTH-1];

  always_comb begin
    // LRCLK edges may land a clk before the BCLK fall they belong to
    lr_rise    = lr_r | rpend_q;
    lr_fall    = lr_f | fpend_q;
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    enter_left = 1'b0;
    short_slot = 1'b0;
    long_slot  = 1'b0;
    unique case (state_q)
      UNLOCKED: begin
        cnt_d = '0;
        if (lr_fall) begin
          state_d    = LEFT;
          enter_left = 1'b1;
        end
      end
      LEFT: begin
        if (lr_rise) begin
          state_d    = RIGHT;
          cnt_d      = '0;
          short_slot = cnt_q < CW'(WIDTH);
        end
      end
      RIGHT: begin
        if (lr_fall) begin
          state_d    = LEFT;
          cnt_d      = '0;
          enter_left = 1'b1;
          short_slot = cnt_q < CW'(WIDTH);
        end
      end
      default: state_d = UNLOCKED;
    endcase
    if (state_d != UNLOCKED && cnt_d > CW'(2*SLOT)) begin
      long_slot = 1'b1;
      state_d   = UNLOCKED;
      cnt_d     = '0;
    end
    shl_d   = enter_left ? TxLeft  : shl_q;
    shr_d   = enter_left ? TxRight : shr_q;
    tx_word = (state_d == LEFT) ? shl_d : shr_d;
    // Wraps high before the first data bit, so one compare covers both ends
    tx_pos  = cnt_d - CW'(OFF);
    tx_sh   = tx_word << tx_pos;
    sdo_d   = (state_d != UNLOCKED) && (tx_pos < CW'(WIDTH))
              && tx_sh[WIDTH-1];
    rx_pos  = cnt_q - CW'(OFF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_q       <= '0;
      state_q    <= UNLOCKED;
      cnt_q      <= '0;
      rpend_q    <= 1'b0;
      fpend_q    <= 1'b0;
      shl_q      <= '0;
      shr_q      <= '0;
      rxl_q      <= '0;
      rxr_q      <= '0;
      rx_left_q  <= '0;
      rx_right_q <= '0;
      sdo_q      <= 1'b0;
      rxv_q      <= 1'b0;
      txl_q      <= 1'b0;
      err_q      <= 1'b0;
      lok_q      <= 1'b0;
    end else begin
      rxv_q <= 1'b0;
      txl_q <= 1'b0;
      sd_q  <= {sd_q[SYNC_DEPTH-2:0], SDATA_IN};
      if (bclk_f) begin
        rpend_q <= 1'b0;
        fpend_q <= 1'b0;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        shl_q   <= shl_d;
        shr_q   <= shr_d;
        sdo_q   <= sdo_d;
        txl_q   <= enter_left;
        if (short_slot || long_slot) err_q <= 1'b1;
        if (enter_left || short_slot) lok_q <= 1'b0;
      end else begin
        if (lr_r) rpend_q <= 1'b1;
        if (lr_f) fpend_q <= 1'b1;
      end
      if (bclk_r && rx_pos < CW'(WIDTH)) begin
        if (state_q == LEFT) begin
          rxl_q <= {rxl_q[WIDTH-2:0], sd};
          if (rx_pos == CW'(WIDTH-1)) lok_q <= 1'b1;
        end
        if (state_q == RIGHT) begin
          rxr_q <= {rxr_q[WIDTH-2:0], sd};
          if (rx_pos == CW'(WIDTH-1) && lok_q) begin
            rx_left_q  <= rxl_q;
            rx_right_q <= {rxr_q[WIDTH-2:0], sd};
            rxv_q      <= 1'b1;
          end
        end
      end
    end
  end

  assign SDATA_OUT = sdo_q;
  assign RxLeft    = rx_left_q;
  assign RxRight   = rx_right_q;
  assign RxValid   = rxv_q;
  assign TxLatch   = txl_q;
  assign Locked    = (state_q != UNLOCKED);
  assign SyncErr   = err_q;

endmodule

// File: tb/tb_i2s_slave_port.sv
// Scoreboard bench for i2s_slave_port with a BCLK-level master model.
module tb_i2s_slave_port;

  localparam int W = 24;
  localparam int S = 32;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int OFF = 0;
`else
  localparam int OFF = 1;
`endif

  logic clk = 1'b0;
  logic reset, BCLK, LRCLK, SDATA_IN, SDATA_OUT;
  logic [W-1:0] TxLeft, TxRight, RxLeft, RxRight;
  logic RxValid, TxLatch, Locked, SyncErr;

  i2s_slave_port #(.WIDTH(W), .SLOT(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .BCLK      (BCLK),
    .LRCLK     (LRCLK),
    .SDATA_IN  (SDATA_IN),
    .SDATA_OUT (SDATA_OUT),
    .TxLeft    (TxLeft),
    .TxRight   (TxRight),
    .RxLeft    (RxLeft),
    .RxRight   (RxRight),
    .RxValid   (RxValid),
    .TxLatch   (TxLatch),
    .Locked    (Locked),
    .SyncErr   (SyncErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int latch_seen = 0;
  int rx_seen = 0;
  logic prev_v = 1'b0;

  logic           txq[$];
  logic [2*W-1:0] rxq[$];

  // Reference model of the slave, advanced once per BCLK fall
  logic         m_lock = 1'b0;
  logic         m_prev = 1'b0;
  logic         m_ch = 1'b0;
  int           m_pos = 0;
  logic         m_err = 1'b0;
  logic         m_left_ok = 1'b0;
  logic [W-1:0] m_tx [2];
  logic [W-1:0] m_rx_left;
  int           m_latch = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_enter_left();
    m_tx[0] = TxLeft;
    m_tx[1] = TxRight;
    m_latch++;
    m_left_ok = 1'b0;
  endtask

  task automatic model_reset();
    m_lock = 1'b0;
    m_prev = 1'b0;
    m_err = 1'b0;
    m_left_ok = 1'b0;
    m_pos = 0;
  endtask

  task automatic model_fall(input logic lr, input logic [W-1:0] wd);
    int b;
    logic eb;
    if (!m_lock) begin
      if (m_prev && !lr) begin
        m_lock = 1'b1;
        m_ch = 1'b0;
        m_pos = 0;
        model_enter_left();
      end
    end else if (lr != m_ch) begin
      if (m_pos < W) begin
        m_err = 1'b1;
        m_left_ok = 1'b0;
      end
      m_ch = lr;
      m_pos = 0;
      if (!lr) model_enter_left();
    end else begin
      m_pos++;
      if (m_pos > 2*S) begin
        m_lock = 1'b0;
        m_err = 1'b1;
      end
    end
    m_prev = lr;
    b = m_pos - OFF;
    eb = 1'b0;
    if (m_lock && b >= 0 && b < W) eb = m_tx[m_ch][W-1-b];
    txq.push_back(eb);
    if (m_lock && b == W-1) begin
      if (!m_ch) begin
        m_left_ok = 1'b1;
        m_rx_left = wd;
      end else if (m_left_ok) begin
        rxq.push_back({m_rx_left, wd});
      end
    end
  endtask

  task automatic check_reset_outs();
    check("reset_outs",
          {SDATA_OUT, RxValid, TxLatch, Locked, SyncErr, RxLeft, RxRight},
          64'd0);
  endtask

  task automatic bclk_cycle(input logic lr, input logic sd,
                            input logic [W-1:0] wd, input bit do_rst);
    BCLK = 1'b0;
    LRCLK = lr;
    SDATA_IN = sd;
    model_fall(lr, wd);
    #80;
    BCLK = 1'b1;
    if (do_rst) begin
      #20 reset = 1'b1;
      #33 check_reset_outs();
      #7 reset = 1'b0;
      model_reset();
      #20;
    end else begin
      #80;
    end
  endtask

  task automatic send_slot(input logic lr, input logic [W-1:0] wd,
                           input int n, input int rst_at = -1);
    for (int k = 0; k < n; k++) begin
      int b;
      logic sd;
      b = k - OFF;
      sd = (b >= 0 && b < W) ? wd[W-1-b] : 1'($urandom);
      bclk_cycle(lr, sd, wd, k == rst_at);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_slot(1'b0, l, S);
    send_slot(1'b1, r, S);
  endtask

  always @(posedge BCLK) begin
    if (txq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL tx_queue_empty actual=%0h required=none", SDATA_OUT);
    end else begin
      check("sdata_out", 64'(SDATA_OUT), 64'(txq.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (TxLatch) latch_seen++;
    if (RxValid) begin
      rx_seen++;
      check("rxvalid_width", 64'(prev_v), 64'd0);
      if (rxq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual=%0h_%0h required=none",
                 RxLeft, RxRight);
      end else begin
        logic [2*W-1:0] e;
        e = rxq.pop_front();
        check("rx_left", 64'(RxLeft), 64'(e[2*W-1:W]));
        check("rx_right", 64'(RxRight), 64'(e[W-1:0]));
      end
    end
    prev_v = RxValid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, r0;
    logic [W-1:0] a, b;
    reset = 1'b1;
    BCLK = 1'b0;
    LRCLK = 1'b1;
    SDATA_IN = 1'b0;
    TxLeft = 24'hA5A5A5;
    TxRight = 24'h123456;
    #100;
    check_reset_outs();
    reset = 1'b0;
    send_slot(1'b1, '0, 4);
    check("locked_idle", 64'(Locked), 64'(m_lock));

    // Transmit fixed words for three frames
    l0 = latch_seen;
    for (int f = 0; f < 3; f++)
      send_frame(W'($urandom), W'($urandom));
    check("txlatch_3frames", 64'(latch_seen - l0), 64'd3);
    check("locked_s1", 64'(Locked), 64'd1);

    r0 = rx_seen;
    send_frame(24'h800001, 24'h7FFFFF);
    send_frame(24'h800001, 24'h7FFFFF);
    check("rxvalid_s2", 64'(rx_seen - r0), 64'd2);

    // Short left slot
    r0 = rx_seen;
    send_slot(1'b0, 24'h5A5A5A, 10);
    send_slot(1'b1, 24'h3C3C3C, S);
    check("syncerr_short", 64'(SyncErr), 64'(m_err));
    check("locked_short", 64'(Locked), 64'd1);
    check("rxvalid_short", 64'(rx_seen - r0), 64'd0);
    send_frame(24'h0F0F0F, 24'hF0F0F0);
    check("rxvalid_after_short", 64'(rx_seen - r0), 64'd1);

    send_slot(1'b1, '0, 4, 1);
    check("syncerr_cleared", 64'(SyncErr), 64'd0);

    // Long left slot
    send_frame(24'h111111, 24'h222222);
    send_slot(1'b0, 24'h333333, 70);
    check("locked_long", 64'(Locked), 64'(m_lock));
    check("syncerr_long", 64'(SyncErr), 64'd1);
    check("sdata_unlocked", 64'(SDATA_OUT), 64'd0);
    send_slot(1'b1, '0, S);
    check("still_unlocked", 64'(Locked), 64'd0);
    r0 = rx_seen;
    send_frame(24'h444444, 24'h555555);
    check("relocked", 64'(Locked), 64'd1);
    check("rxvalid_relock", 64'(rx_seen - r0), 64'd1);

    // Reset in the right slot
    send_slot(1'b0, 24'h666666, S);
    send_slot(1'b1, 24'h777777, S, 5);
    r0 = rx_seen;
    send_slot(1'b0, 24'h888888, S);
    check("rxvalid_after_rst_half", 64'(rx_seen - r0), 64'd0);
    send_slot(1'b1, 24'h999999, S);
    check("rxvalid_after_rst_frame", 64'(rx_seen - r0), 64'd1);

    // Random words, TX words changed mid-frame
    for (int f = 0; f < 4; f++) begin
      a = W'($urandom);
      b = W'($urandom);
      send_slot(1'b0, a, S);
      TxLeft = W'($urandom);
      TxRight = W'($urandom);
      send_slot(1'b1, b, S);
    end
    send_slot(1'b0, '0, 4);
    #200;
    check("rx_queue_drained", 64'(rxq.size()), 64'd0);
    check("txlatch_total", 64'(latch_seen), 64'(m_latch));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
